// File: rtl/dmem_bytelane.sv
// Purpose: RV32 data memory with byte/half/word stores (lane enables) and sign/zero-extended loads.
// Latency: resp_valid pulses RD_LATENCY cycles after the accepting cycle; one request per RD_LATENCY+1 cycles.
// Backpressure: req_ready is high only while idle; requests are held off until the response has been issued.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata request side;
//        resp_valid/resp_rdata/resp_fault one-cycle response (rdata and fault are 0 outside the response cycle).
module dmem_bytelane #(
   parameter int DEPTH_WORDS = 256,
   parameter int RD_LATENCY  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [1:0]  cnt;
   logic [31:0] rdata_q;
   logic        fault_q;
   logic        accept;

   logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic          out_of_range, misalign, legal, fault;
   logic [3:0]    be;
   logic [31:0]   wlane, rd_word, load_val;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;

   // Request decode: fault detection, store lane enables, load extraction.
   always_comb begin
      word_idx     = req_addr[AW+1:2];
      lane         = req_addr[1:0];
      out_of_range = (req_addr[31:2] >= 30'(DEPTH_WORDS));
      misalign     = 1'b0;
      legal        = 1'b0;
      case (req_funct3)
         3'b000: legal = 1'b1;
         3'b001: begin legal = 1'b1; misalign = lane[0]; end
         3'b010: begin legal = 1'b1; misalign = (lane != 2'd0); end
         // Unsigned widths exist only for loads.
         3'b100: legal = !req_we;
         3'b101: begin legal = !req_we; misalign = lane[0]; end
         default: legal = 1'b0;
      endcase
      fault = out_of_range || misalign || !legal;

      // Store data is replicated across lanes so the enables alone pick the target bytes.
      case (req_funct3[1:0])
         2'b00:   begin be = 4'b0001 << lane;                   wlane = {4{req_wdata[7:0]}};  end
         2'b01:   begin be = lane[1] ? 4'b1100 : 4'b0011;       wlane = {2{req_wdata[15:0]}}; end
         default: begin be = 4'b1111;                           wlane = req_wdata;            end
      endcase

      rd_word  = mem[word_idx];
      byte_sel = rd_word[{lane, 3'b000} +: 8];
      half_sel = rd_word[{lane[1], 4'b0000} +: 16];
      case (req_funct3)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = rd_word;
      endcase
   end

   assign accept = req_valid && req_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = (RD_LATENCY == 1) ? RESP : WAIT;
         end
         WAIT: if (cnt == 2'd0) state_nxt = RESP;
         RESP: begin
            resp_valid = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      resp_rdata = resp_valid ? rdata_q : 32'd0;
      resp_fault = resp_valid && fault_q;
   end

   // The load result is fully formed at acceptance so the wait cycles only model latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= 2'd0;
         rdata_q <= 32'd0;
         fault_q <= 1'b0;
      end else if (accept) begin
         cnt     <= (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;
         fault_q <= fault;
         rdata_q <= (fault || req_we) ? 32'd0 : load_val;
      end else if (state == WAIT && cnt != 2'd0) begin
         cnt <= cnt - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
      end else if (accept && req_we && !fault) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[word_idx][b*8 +: 8] <= wlane[b*8 +: 8];
      end
   end

endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        v1, v3, rdy1, rdy3, we;
   logic [2:0]  f3;
   logic [31:0] addr, wdata;
   logic        rv1, rv3, ft1, ft3;
   logic [31:0] rd1, rd3;

   always #5 clk = ~clk;

   dmem_bytelane #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(we),
      .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rv1), .resp_rdata(rd1), .resp_fault(ft1));

   dmem_bytelane #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_we(we),
      .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
      .resp_valid(rv3), .resp_rdata(rd3), .resp_fault(ft3));

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          acc;
   } exp_t;

   exp_t       q1[$];
   exp_t       q3[$];
   logic [7:0] mb [DEPTH*4];
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   int         resp3_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte-addressed little-endian reference memory.
   function automatic void model_clear();
      for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'd0;
   endfunction

   function automatic void model(input logic w, input logic [2:0] fn, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] r, output logic f);
      int unsigned size;
      logic        legal;
      logic [31:0] val;
      size  = (fn[1:0] == 2'd0) ? 1 : (fn[1:0] == 2'd1) ? 2 : 4;
      legal = w ? (fn <= 3'd2) : (fn <= 3'd2 || fn == 3'd4 || fn == 3'd5);
      f     = !legal || ((a / 4) >= DEPTH) || ((a % size) != 0);
      r     = 32'd0;
      if (!f) begin
         if (w) begin
            for (int i = 0; i < int'(size); i++) mb[a + 32'(i)] = d[8*i +: 8];
         end else begin
            val = 32'd0;
            for (int i = 0; i < int'(size); i++) val = val | (32'(mb[a + 32'(i)]) << (8*i));
            if (fn == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
            if (fn == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
            r = val;
         end
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_resp(input string nm, input int lat, input exp_t e,
                             input logic [31:0] rd, input logic f);
      vectors++;
      if (rd !== e.rdata || f !== e.fault || cyc != e.acc + lat - 1) begin
         miscompares++;
         $display("FAIL resp_%s: got rdata=%h fault=%b cycle=%0d expected rdata=%h fault=%b cycle=%0d",
                  nm, rd, f, cyc, e.rdata, e.fault, e.acc + lat - 1);
      end
   endtask

   // Monitor: pops the scoreboard whenever a DUT presents a response.
   always @(negedge clk) begin
      if (rv1) begin
         if (q1.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_resp_L1: resp_valid=1 expected no response (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check_resp("L1", 1, e, rd1, ft1);
         end
      end else if (rd1 !== 32'd0 || ft1 !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_outputs_L1: rdata=%h fault=%b expected 0/0", rd1, ft1);
      end
      if (rv3) begin
         resp3_cnt++;
         if (q3.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_resp_L3: resp_valid=1 expected no response (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q3.pop_front();
            check_resp("L3", 3, e, rd3, ft3);
         end
      end else if (rd3 !== 32'd0 || ft3 !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_outputs_L3: rdata=%h fault=%b expected 0/0", rd3, ft3);
      end
   end

   task automatic drain();
      int n = 0;
      while ((q1.size() != 0 || q3.size() != 0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (q1.size() != 0 || q3.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: pending %0d/%0d responses expected 0/0", q1.size(), q3.size());
         q1.delete();
         q3.delete();
      end
      @(negedge clk);
   endtask

   // Issue one request at a negedge with both DUTs idle; waits for the responses.
   task automatic issue(input bit d1, input bit d3, input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r;
      logic        f;
      we = w; f3 = fn; addr = a; wdata = d; v1 = d1; v3 = d3;
      model(w, fn, a, d, r, f);
      if (d1) q1.push_back('{rdata: r, fault: f, acc: cyc + 1});
      if (d3) q3.push_back('{rdata: r, fault: f, acc: cyc + 1});
      @(negedge clk);
      v1 = 1'b0; v3 = 1'b0;
      if (d1) chk("ready_low_L1", {31'd0, rdy1}, 32'd0);
      if (d3) chk("ready_low_L3", {31'd0, rdy3}, 32'd0);
      if (d1) begin
         @(negedge clk);
         chk("ready_back_L1", {31'd0, rdy1}, 32'd1);
      end
      drain();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc[4];
      int base;
      logic [31:0] a, r;
      logic f;
      reset = 1'b1; v1 = 1'b0; v3 = 1'b0; we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset_ready_L1", {31'd0, rdy1}, 32'd1);
      chk("reset_ready_L3", {31'd0, rdy3}, 32'd1);
      chk("reset_rvalid", {30'd0, rv1, rv3}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed sequence from the byte-lane and fault scenarios.
      issue(1, 1, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
      issue(1, 1, 1'b0, 3'b010, 32'h8, 32'h0);
      issue(1, 1, 1'b1, 3'b000, 32'h9, 32'h12345680);
      issue(1, 1, 1'b0, 3'b000, 32'h9, 32'h0);
      issue(1, 1, 1'b0, 3'b100, 32'h9, 32'h0);
      issue(1, 1, 1'b0, 3'b010, 32'h8, 32'h0);
      issue(1, 1, 1'b1, 3'b001, 32'hA, 32'h8001);
      issue(1, 1, 1'b0, 3'b101, 32'hA, 32'h0);
      issue(1, 1, 1'b0, 3'b001, 32'hA, 32'h0);
      issue(1, 1, 1'b0, 3'b001, 32'h3, 32'h0);
      issue(1, 1, 1'b1, 3'b010, 32'h6, 32'hFFFFFFFF);
      issue(1, 1, 1'b0, 3'b010, 32'h4, 32'h0);
      issue(1, 1, 1'b0, 3'b010, 32'h400, 32'h0);
      issue(1, 1, 1'b0, 3'b011, 32'h0, 32'h0);
      issue(1, 1, 1'b1, 3'b100, 32'h0, 32'h55);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 9))
            0:       a = $urandom();
            1:       a = 32'h400 + $urandom_range(0, 15);
            2:       a = $urandom_range(0, DEPTH*4 - 1);
            default: a = $urandom_range(0, 63);
         endcase
         issue(1, 1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom());
      end

      // Held req_valid on the 3-cycle instance: four back-to-back loads.
      base = resp3_cnt;
      we = 1'b0; v3 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         f3 = 3'b010; addr = 32'(4*k); wdata = 32'd0;
         while (!rdy3 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!rdy3) begin
            miscompares++;
            $display("FAIL held_accept_timeout: ready=0 expected 1");
         end else begin
            model(1'b0, 3'b010, 32'(4*k), 32'd0, r, f);
            q3.push_back('{rdata: r, fault: f, acc: cyc + 1});
            acc[k] = cyc + 1;
            @(negedge clk);
         end
      end
      v3 = 1'b0;
      drain();
      for (int k = 1; k < 4; k++) chk("accept_spacing", 32'(acc[k] - acc[k-1]), 32'd4);
      chk("held_resp_count", 32'(resp3_cnt - base), 32'd4);

      // Reset while the 3-cycle instance is waiting.
      issue(1, 1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
      we = 1'b0; f3 = 3'b010; addr = 32'h20; v3 = 1'b1;
      @(negedge clk);
      v3 = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      chk("ready_after_reset_L1", {31'd0, rdy1}, 32'd1);
      chk("ready_after_reset_L3", {31'd0, rdy3}, 32'd1);
      repeat (5) @(negedge clk);
      issue(1, 1, 1'b0, 3'b010, 32'h20, 32'h0);
      issue(1, 1, 1'b0, 3'b010, 32'h8, 32'h0);

      // Request coincident with reset must not be accepted.
      issue(1, 1, 1'b1, 3'b010, 32'h10, 32'h55AA55AA);
      we = 1'b1; f3 = 3'b010; addr = 32'h14; wdata = 32'h11111111; v1 = 1'b1; v3 = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; v1 = 1'b0; v3 = 1'b0;
      model_clear();
      chk("ready_after_reset_req", {30'd0, rdy1, rdy3}, 32'd3);
      repeat (5) @(negedge clk);
      issue(1, 1, 1'b0, 3'b010, 32'h14, 32'h0);
      issue(1, 1, 1'b0, 3'b010, 32'h10, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
